// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
//   time_t : packed display time {hour, minute, second, centi}
//   fsm_e  : main stopwatch state
//   SEC_MAX / MIN_MAX : last value of the second / minute fields
package stopwatch_pkg;

  typedef struct packed {
    logic [6:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [6:0] centi;
  } time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } fsm_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/lap_buffer.sv
// Circular store of captured lap times.
//   clock, reset_n : system clock, asynchronous active-low reset
//   write, wdata   : append one entry (overwrites the oldest when full)
//   flush          : discard all entries
//   rd_idx         : read address relative to the oldest stored entry
//   rd_data        : combinational read data
//   count          : number of stored entries, saturating at LAP_DEPTH
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter  int LAP_DEPTH = 8,
  localparam int IW        = $clog2(LAP_DEPTH),
  localparam int CW        = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          write,
  input  logic          flush,
  input  time_t         wdata,
  input  logic [IW-1:0] rd_idx,
  output time_t         rd_data,
  output logic [CW-1:0] count
);

  logic [IW-1:0] wptr;
  logic [IW-1:0] phys;
  time_t         mem [LAP_DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (write) begin
      wptr <= (wptr == IW'(LAP_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (count != CW'(LAP_DEPTH)) count <= count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (write && !flush) mem[wptr] <= wdata;
  end

  // Oldest entry sits count slots behind the write pointer; the +LAP_DEPTH
  // keeps the sum non-negative so the modulo also works for non-power-of-2 depths.
  always_comb begin
    phys = IW'((int'(wptr) + LAP_DEPTH - int'(count) + int'(rd_idx)) % LAP_DEPTH);
  end

  assign rd_data = mem[phys];

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch engine with lap capture, frozen-lap display and lap recall.
//   clock, reset_n   : system clock, asynchronous active-low reset
//   start_pause, lap, reset, clear, recall : debounced button levels
//   hour/minute/second/centi : displayed time (recall > frozen > live)
//   running, frozen, recalling : status flags
//   recall_idx       : recalled entry, 0 = oldest
//   lap_count        : stored laps (saturates at LAP_DEPTH), lap_full when saturated
module lap_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter  int CLK_HZ    = 50_000_000,
  parameter  int TICK_HZ   = 100,
  parameter  int HOUR_MAX  = 99,
  parameter  int LAP_DEPTH = 8,
  localparam int IW        = $clog2(LAP_DEPTH),
  localparam int CW        = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start_pause,
  input  logic          lap,
  input  logic          reset,
  input  logic          clear,
  input  logic          recall,
  output logic [6:0]    hour,
  output logic [5:0]    minute,
  output logic [5:0]    second,
  output logic [6:0]    centi,
  output logic          running,
  output logic          frozen,
  output logic          recalling,
  output logic [IW-1:0] recall_idx,
  output logic [CW-1:0] lap_count,
  output logic          lap_full
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  fsm_e          state;
  logic [PW-1:0] presc;
  time_t         live, latched, shown, rd_data;
  logic [4:0]    btn_r, btn_q, edges;
  logic          tick;
  logic          act_clear, act_reset, act_sp, act_lap, act_recall;
  logic          buf_write, buf_flush;

  function automatic time_t advance(input time_t t);
    time_t n;
    n = t;
    if (t.centi != 7'(TICK_HZ - 1)) begin
      n.centi = t.centi + 7'd1;
    end else begin
      n.centi = '0;
      if (t.second != 6'(SEC_MAX)) begin
        n.second = t.second + 6'd1;
      end else begin
        n.second = '0;
        if (t.minute != 6'(MIN_MAX)) begin
          n.minute = t.minute + 6'd1;
        end else begin
          n.minute = '0;
          n.hour   = (t.hour == 7'(HOUR_MAX)) ? '0 : t.hour + 7'd1;
        end
      end
    end
    return n;
  endfunction

  // Bit order is also the priority order: clear, reset, start_pause, lap, recall.
  assign edges = btn_r & ~btn_q;

  // Only the highest-priority edge acts; the rest are dropped.
  always_comb begin
    act_clear  = edges[4];
    act_reset  = edges[3] & ~edges[4];
    act_sp     = edges[2] & ~|edges[4:3];
    act_lap    = edges[1] & ~|edges[4:2];
    act_recall = edges[0] & ~|edges[4:1];
  end

  assign tick      = (state == RUN) && (presc == PW'(DIV - 1));
  assign buf_write = act_lap && (state == RUN);
  assign buf_flush = act_clear && (state != RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_r      <= '0;
      btn_q      <= '0;
      state      <= IDLE;
      running    <= 1'b0;
      presc      <= '0;
      live       <= '0;
      frozen     <= 1'b0;
      recalling  <= 1'b0;
      recall_idx <= '0;
    end else begin
      btn_r <= {clear, reset, start_pause, lap, recall};
      btn_q <= btn_r;

      if (state == RUN) presc <= tick ? '0 : presc + 1'b1;
      if (tick) live <= advance(live);

      if (act_clear) begin
        if (state != RUN) begin
          recalling  <= 1'b0;
          recall_idx <= '0;
        end
      end else if (act_reset) begin
        // In RUN a reset only releases a frozen display; elsewhere it zeroes time.
        if (state == RUN) begin
          frozen <= 1'b0;
        end else begin
          live    <= '0;
          presc   <= '0;
          state   <= IDLE;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      end else if (act_sp) begin
        recalling  <= 1'b0;
        recall_idx <= '0;
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (act_lap) begin
        frozen <= (state == RUN);
      end else if (act_recall) begin
        if (state != RUN && lap_count != '0) begin
          if (!recalling) begin
            recalling  <= 1'b1;
            recall_idx <= '0;
          end else if (CW'(recall_idx) == lap_count - 1'b1) begin
            recalling  <= 1'b0;
            recall_idx <= '0;
          end else begin
            recall_idx <= recall_idx + 1'b1;
          end
        end
      end
    end
  end

  // Captures the pre-tick live time of the lap cycle.
  always_ff @(posedge clock) begin
    if (buf_write) latched <= live;
  end

  lap_buffer #(.LAP_DEPTH(LAP_DEPTH)) u_lap_buffer (
    .clock   (clock),
    .reset_n (reset_n),
    .write   (buf_write),
    .flush   (buf_flush),
    .wdata   (live),
    .rd_idx  (recall_idx),
    .rd_data (rd_data),
    .count   (lap_count)
  );

  always_comb begin
    shown = live;
    if (recalling)   shown = rd_data;
    else if (frozen) shown = latched;
  end

  assign hour     = shown.hour;
  assign minute   = shown.minute;
  assign second   = shown.second;
  assign centi    = shown.centi;
  assign lap_full = (lap_count == CW'(LAP_DEPTH));

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Directed bench: unit A (1 kHz clock, 100 ticks/s, 4 laps) covers run/pause,
// lap freeze, priority, circular overwrite, recall, clear and async reset.
// Unit B (one tick per clock, 2 ticks/s, HOUR_MAX=1) covers the time wraps.
module tb_lap_stopwatch_core;

  localparam logic [4:0] CLR = 5'b10000;
  localparam logic [4:0] RST = 5'b01000;
  localparam logic [4:0] SP  = 5'b00100;
  localparam logic [4:0] LAP = 5'b00010;
  localparam logic [4:0] RCL = 5'b00001;

  logic       clock;
  logic       rst_n;
  logic [4:0] a_btn, b_btn;

  logic [6:0] a_hour, b_hour, a_centi, b_centi;
  logic [5:0] a_minute, b_minute, a_second, b_second;
  logic       a_running, a_frozen, a_recalling, a_full;
  logic       b_running, b_frozen, b_recalling, b_full;
  logic [1:0] a_idx;
  logic [2:0] a_cnt;
  logic [0:0] b_idx;
  logic [1:0] b_cnt;

  logic [25:0] a_disp, b_disp;
  logic [3:0]  a_stat, b_stat;

  int checks   = 0;
  int failures = 0;

  assign a_disp = {a_hour, a_minute, a_second, a_centi};
  assign b_disp = {b_hour, b_minute, b_second, b_centi};
  assign a_stat = {a_running, a_frozen, a_recalling, a_full};
  assign b_stat = {b_running, b_frozen, b_recalling, b_full};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  lap_stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(99), .LAP_DEPTH(4)) dut_a (
    .clock(clock), .reset_n(rst_n),
    .start_pause(a_btn[2]), .lap(a_btn[1]), .reset(a_btn[3]), .clear(a_btn[4]), .recall(a_btn[0]),
    .hour(a_hour), .minute(a_minute), .second(a_second), .centi(a_centi),
    .running(a_running), .frozen(a_frozen), .recalling(a_recalling),
    .recall_idx(a_idx), .lap_count(a_cnt), .lap_full(a_full)
  );

  lap_stopwatch_core #(.CLK_HZ(2), .TICK_HZ(2), .HOUR_MAX(1), .LAP_DEPTH(2)) dut_b (
    .clock(clock), .reset_n(rst_n),
    .start_pause(b_btn[2]), .lap(b_btn[1]), .reset(b_btn[3]), .clear(b_btn[4]), .recall(b_btn[0]),
    .hour(b_hour), .minute(b_minute), .second(b_second), .centi(b_centi),
    .running(b_running), .frozen(b_frozen), .recalling(b_recalling),
    .recall_idx(b_idx), .lap_count(b_cnt), .lap_full(b_full)
  );

  function automatic logic [31:0] tm(input int h, input int m, input int s, input int c);
    return 32'({7'(h), 6'(m), 6'(s), 7'(c)});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Input is seen at the first edge, the action happens at the second.
  task automatic press_a(input logic [4:0] m);
    a_btn = m;
    step(1);
    a_btn = '0;
    step(1);
  endtask

  task automatic press_b(input logic [4:0] m);
    b_btn = m;
    step(1);
    b_btn = '0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_btn = '0;
    b_btn = '0;
    step(2);
    chk("rst_disp",  32'(a_disp), tm(0, 0, 0, 0));
    chk("rst_stat",  32'(a_stat), 32'h0);
    chk("rst_cnt",   32'(a_cnt),  32'd0);
    chk("rst_idx",   32'(a_idx),  32'd0);
    chk("rst_b",     32'(b_disp), tm(0, 0, 0, 0));
    rst_n = 1'b1;
    step(1);

    // Run one second, pause, hold.
    press_a(SP);
    step(1000);
    chk("run1s_disp", 32'(a_disp), tm(0, 0, 1, 0));
    chk("run1s_stat", 32'(a_stat), 32'b1000);
    press_a(SP);
    chk("pause_stat", 32'(a_stat), 32'b0000);
    chk("pause_disp", 32'(a_disp), tm(0, 0, 1, 0));
    step(500);
    chk("pause_hold", 32'(a_disp), tm(0, 0, 1, 0));

    // Resume with prescaler at 2, lap at 1.23 s.
    press_a(SP);
    step(230);
    press_a(LAP);
    chk("lap_disp",   32'(a_disp), tm(0, 0, 1, 23));
    chk("lap_stat",   32'(a_stat), 32'b1100);
    step(50);
    chk("lap_frozen", 32'(a_disp), tm(0, 0, 1, 23));
    press_a(RST);
    chk("unfrz_stat", 32'(a_stat), 32'b1000);
    chk("unfrz_disp", 32'(a_disp), tm(0, 0, 1, 28));
    chk("unfrz_cnt",  32'(a_cnt),  32'd1);

    // Reset in RUN unfrozen is ignored; simultaneous start_pause+lap only pauses.
    press_a(RST);
    step(20);
    chk("rst_ign_disp", 32'(a_disp), tm(0, 0, 1, 30));
    chk("rst_ign_stat", 32'(a_stat), 32'b1000);
    press_a(SP | LAP);
    chk("prio_stat", 32'(a_stat), 32'b0000);
    chk("prio_cnt",  32'(a_cnt),  32'd1);
    chk("prio_disp", 32'(a_disp), tm(0, 0, 1, 31));

    // Soft reset from PAUSE, clear in IDLE.
    press_a(RST);
    chk("soft_rst_disp", 32'(a_disp), tm(0, 0, 0, 0));
    chk("soft_rst_stat", 32'(a_stat), 32'b0000);
    press_a(CLR);
    chk("clr_idle_cnt", 32'(a_cnt), 32'd0);

    // Five laps at 1..5 s into a 4-deep buffer.
    press_a(SP);
    step(1004);
    press_a(LAP);
    for (int i = 0; i < 4; i++) begin
      step(998);
      press_a(LAP);
    end
    press_a(SP);
    chk("full_cnt",  32'(a_cnt),  32'd4);
    chk("full_stat", 32'(a_stat), 32'b0101);
    chk("full_disp", 32'(a_disp), tm(0, 0, 5, 0));

    for (int k = 0; k < 4; k++) begin
      press_a(RCL);
      chk("rcl_stat", 32'(a_stat), 32'b0111);
      chk("rcl_idx",  32'(a_idx),  32'(k));
      chk("rcl_disp", 32'(a_disp), tm(0, 0, k + 2, 0));
    end
    press_a(RCL);
    chk("rcl_end_stat", 32'(a_stat), 32'b0101);
    chk("rcl_end_idx",  32'(a_idx),  32'd0);
    chk("rcl_end_disp", 32'(a_disp), tm(0, 0, 5, 0));

    // Clear in PAUSE keeps time; lap in PAUSE unfreezes.
    press_a(CLR);
    chk("clr_pause_cnt",  32'(a_cnt),  32'd0);
    chk("clr_pause_disp", 32'(a_disp), tm(0, 0, 5, 0));
    chk("clr_pause_stat", 32'(a_stat), 32'b0100);
    press_a(LAP);
    chk("lap_pause_stat", 32'(a_stat), 32'b0000);
    chk("lap_pause_disp", 32'(a_disp), tm(0, 0, 5, 0));

    // Three laps in RUN; recall and clear are ignored while running.
    press_a(SP);
    press_a(LAP);
    press_a(LAP);
    press_a(LAP);
    press_a(RCL);
    press_a(CLR);
    chk("run3_cnt",  32'(a_cnt),  32'd3);
    chk("run3_stat", 32'(a_stat), 32'b1100);

    // Asynchronous reset between clock edges.
    rst_n = 1'b0;
    #1;
    chk("async_disp", 32'(a_disp), tm(0, 0, 0, 0));
    chk("async_stat", 32'(a_stat), 32'b0000);
    chk("async_cnt",  32'(a_cnt),  32'd0);
    chk("async_idx",  32'(a_idx),  32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Wrap checks on unit B: one tick per clock, centi range 0..1.
    press_b(SP);
    step(7199);
    chk("b_last_min", 32'(b_disp), tm(0, 59, 59, 1));
    chk("b_running",  32'(b_stat), 32'b1000);
    step(1);
    chk("b_hour1",    32'(b_disp), tm(1, 0, 0, 0));
    step(7200);
    chk("b_wrap",     32'(b_disp), tm(0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
